reg_capture_fifo: RTL

Parametrised successor to the PhyWhisperer sniff-FIFO register front end, running on a single clock.
- Holds the capture FIFO, its status flags, fill count and an arm/capture state machine behind the reg_main register bus.
- Storage is in-fabric: depth, entry width and register addresses are parameters; there is no vendor FIFO IP and no CDC.
- Unlike the previous block: the head entry stays stable for the whole multi-byte read, flags are sticky and write-1-to-clear, and capture length is bounded.

---
 rtl/reg_capture_fifo_pkg.sv | 46 ++++
 rtl/reg_capture_fifo_if.sv | 32 +++
 rtl/reg_capture_fifo_core.sv | 63 ++++++
 rtl/reg_capture_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_capture_fifo_pkg.sv
// ============================================================================
// Module   : reg_capture_fifo_pkg
// Brief    : Shared state encoding, STAT/CTRL bit indices, default addresses.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reg_capture_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int c_stat_empty     = 0;
  localparam int c_stat_underflow = 1;
  localparam int c_stat_empty_thr = 2;
  localparam int c_stat_full      = 3;
  localparam int c_stat_overflow  = 4;
  localparam int c_stat_full_thr  = 5;

  localparam int c_ctrl_arm = 0;

  localparam int c_reg_fifo_rd   = 10;
  localparam int c_reg_fifo_stat = 11;
  localparam int c_reg_fifo_cnt  = 12;
  localparam int c_reg_fifo_ctrl = 13;
  localparam int c_reg_fifo_len  = 14;

  // Byte idx of a register image that is nb bytes wide; 0 beyond its width.
  function automatic logic [7:0] sel_byte(input logic [47:0] v,
                                          input logic [15:0] idx,
                                          input int          nb);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 6; i++)
      if (i < nb && idx == 16'(i)) b = v[i*8 +: 8];
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_capture_fifo_if.sv
// ============================================================================
// Module   : reg_capture_fifo_if
// Brief    : reg_main register bus bundle with master/slave views.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface reg_capture_fifo_if #(
  parameter int pADDR_WIDTH = 6
);
  logic [pADDR_WIDTH-1:0] reg_address;
  logic [15:0]            reg_bytecnt;
  logic                   reg_addrvalid;
  logic                   reg_read;
  logic                   reg_write;
  logic [7:0]             write_data;
  logic [7:0]             read_data;

  modport master (
    output reg_address, reg_bytecnt, reg_addrvalid, reg_read, reg_write,
           write_data,
    input  read_data
  );

  modport slave (
    input  reg_address, reg_bytecnt, reg_addrvalid, reg_read, reg_write,
           write_data,
    output read_data
  );
endinterface

`default_nettype wire

// File: rtl/reg_capture_fifo_core.sv
// ============================================================================
// Module   : capture_fifo_core
// Brief    : In-fabric FIFO storage, wrapping pointers, fill count, flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module capture_fifo_core #(
  parameter int pDATA_WIDTH = 18,
  parameter int pDEPTH_LOG2 = 9
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   i_flush,
  input  wire logic                   i_push,
  input  wire logic [pDATA_WIDTH-1:0] i_din,
  input  wire logic                   i_pop,
  output logic      [pDATA_WIDTH-1:0] o_head,
  output logic      [pDEPTH_LOG2:0]   o_count,
  output logic                        o_full,
  output logic                        o_empty
);

  localparam int c_depth = 1 << pDEPTH_LOG2;

  logic [pDATA_WIDTH-1:0] r_mem [c_depth];
  logic [pDEPTH_LOG2-1:0] r_wr_ptr;
  logic [pDEPTH_LOG2-1:0] r_rd_ptr;
  logic [pDEPTH_LOG2:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Callers only assert i_push when not full and i_pop when not empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_count[pDEPTH_LOG2];
  assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/reg_capture_fifo.sv
// ============================================================================
// Module   : reg_capture_fifo
// Brief    : Capture FIFO with arm/capture FSM behind the reg_main bus.
//            Optional REG_CAPTURE_FIFO_STATS_EN adds high-water/drop stats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_capture_fifo
  import reg_capture_fifo_pkg::*;
#(
  parameter int                     pDATA_WIDTH    = 18,
  parameter int                     pDEPTH_LOG2    = 9,
  parameter int                     pADDR_WIDTH    = 6,
  parameter logic [pADDR_WIDTH-1:0] pREG_FIFO_RD   = pADDR_WIDTH'(c_reg_fifo_rd),
  parameter logic [pADDR_WIDTH-1:0] pREG_FIFO_STAT = pADDR_WIDTH'(c_reg_fifo_stat),
  parameter logic [pADDR_WIDTH-1:0] pREG_FIFO_CNT  = pADDR_WIDTH'(c_reg_fifo_cnt),
  parameter logic [pADDR_WIDTH-1:0] pREG_FIFO_CTRL = pADDR_WIDTH'(c_reg_fifo_ctrl),
  parameter logic [pADDR_WIDTH-1:0] pREG_FIFO_LEN  = pADDR_WIDTH'(c_reg_fifo_len)
) (
  input  wire logic                   cwusb_clk,
  input  wire logic                   reset_i,
  reg_capture_fifo_if.slave           reg_bus,
  input  wire logic                   I_wr_en,
  input  wire logic [pDATA_WIDTH-1:0] I_din,
  input  wire logic                   I_match,
  output logic                        O_arm,
  output logic                        O_capturing,
  output logic                        O_full
);

  localparam int c_nbytes = (pDATA_WIDTH + 7) / 8;

  state_t                 r_state, w_state_nxt;
  logic                   r_ctrl_arm, r_udf, r_ovf;
  logic [15:0]            r_len, r_thr_empty, r_thr_full, r_cap_cnt, w_cap_cnt_nxt;
  logic [7:0]             r_read_data, w_reg_byte, w_fifo_byte, w_stat;
  logic [pDATA_WIDTH-1:0] w_head;
  logic [c_nbytes*8-1:0]  w_head_pad;
  logic [pDEPTH_LOG2:0]   w_count;
  logic                   w_full, w_empty, w_flush;
  logic                   w_push_req, w_push, w_ovf_evt, w_pop_req, w_pop, w_udf_evt;
  logic                   w_wr_sel, w_ctrl_wr, w_stat_wr, w_rd_fifo, w_rd_reg;
  logic [31:0]            w_stats;

  assign w_flush    = (r_state == ST_FLUSH);
  assign w_push_req = I_wr_en & ((r_state == ST_ARMED) | (r_state == ST_CAPTURE));
  assign w_push     = w_push_req & ~w_full;
  assign w_ovf_evt  = w_push_req & w_full;

  assign w_rd_fifo = reg_bus.reg_addrvalid & reg_bus.reg_read & (reg_bus.reg_address == pREG_FIFO_RD);
  assign w_rd_reg  = reg_bus.reg_addrvalid & reg_bus.reg_read & (reg_bus.reg_address != pREG_FIFO_RD);
  // Pop on the last byte so the head stays put across a multi-byte read.
  assign w_pop_req = w_rd_fifo & (reg_bus.reg_bytecnt == 16'(c_nbytes - 1));
  assign w_pop     = w_pop_req & ~w_empty;
  assign w_udf_evt = w_pop_req & w_empty;

  assign w_wr_sel  = reg_bus.reg_addrvalid & reg_bus.reg_write;
  assign w_ctrl_wr = w_wr_sel & (reg_bus.reg_address == pREG_FIFO_CTRL) & (reg_bus.reg_bytecnt == 16'd0);
  assign w_stat_wr = w_wr_sel & (reg_bus.reg_address == pREG_FIFO_STAT) & (reg_bus.reg_bytecnt == 16'd0);

  capture_fifo_core #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pDEPTH_LOG2 (pDEPTH_LOG2)
  ) u_core (
    .clk     (cwusb_clk),
    .rst     (reset_i),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_din   (I_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_cap_cnt_nxt = r_cap_cnt + 16'((r_state == ST_CAPTURE) && w_push);

  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    O_arm       = 1'b0;
    O_capturing = 1'b0;
    case (r_state)
      ST_FLUSH: w_state_nxt = ST_ARMED;
      ST_ARMED: begin
        O_arm = 1'b1;
        if (I_match) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        O_capturing = 1'b1;
        if (r_len != 16'd0 && w_cap_cnt_nxt == r_len) w_state_nxt = ST_DONE;
      end
      default: ;
    endcase
    // Disarm works from any state; arm only restarts from IDLE or DONE.
    if (w_ctrl_wr) begin
      if (!reg_bus.write_data[c_ctrl_arm])
        w_state_nxt = ST_IDLE;
      else if (r_state == ST_IDLE || r_state == ST_DONE)
        w_state_nxt = ST_FLUSH;
    end
  end

  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      r_ctrl_arm  <= 1'b0;
      r_len       <= '0;
      r_thr_empty <= '0;
      r_thr_full  <= '0;
      r_cap_cnt   <= '0;
      r_udf       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_wr_sel && reg_bus.reg_address == pREG_FIFO_LEN) begin
        case (reg_bus.reg_bytecnt)
          16'd0:   r_len[7:0]  <= reg_bus.write_data;
          16'd1:   r_len[15:8] <= reg_bus.write_data;
          default: ;
        endcase
      end
      if (w_wr_sel && reg_bus.reg_address == pREG_FIFO_CTRL) begin
        case (reg_bus.reg_bytecnt)
          16'd0:   r_ctrl_arm        <= reg_bus.write_data[c_ctrl_arm];
          16'd1:   r_thr_empty[7:0]  <= reg_bus.write_data;
          16'd2:   r_thr_empty[15:8] <= reg_bus.write_data;
          16'd3:   r_thr_full[7:0]   <= reg_bus.write_data;
          16'd4:   r_thr_full[15:8]  <= reg_bus.write_data;
          default: ;
        endcase
      end
      if (w_flush) begin
        r_cap_cnt <= '0;
        r_udf     <= 1'b0;
        r_ovf     <= 1'b0;
      end else begin
        r_cap_cnt <= w_cap_cnt_nxt;
        if (w_udf_evt)
          r_udf <= 1'b1;
        else if (w_stat_wr && reg_bus.write_data[c_stat_underflow])
          r_udf <= 1'b0;
        if (w_ovf_evt)
          r_ovf <= 1'b1;
        else if (w_stat_wr && reg_bus.write_data[c_stat_overflow])
          r_ovf <= 1'b0;
      end
    end
  end

`ifdef REG_CAPTURE_FIFO_STATS_EN
  logic [pDEPTH_LOG2:0] r_hwm;
  logic [15:0]          r_drop;

  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      r_hwm  <= '0;
      r_drop <= '0;
    end else if (w_flush) begin
      r_hwm  <= '0;
      r_drop <= '0;
    end else begin
      if (w_count > r_hwm) r_hwm <= w_count;
      if (w_ovf_evt && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end

  assign w_stats = {r_drop, 16'(r_hwm)};
`else
  assign w_stats = '0;
`endif

  assign w_stat = {2'b00,
                   (16'(w_count) >= r_thr_full),
                   r_ovf,
                   w_full,
                   (16'(w_count) <= r_thr_empty),
                   r_udf,
                   w_empty};

  assign w_head_pad = (c_nbytes*8)'(w_head);

  always_comb begin
    w_fifo_byte = '0;
    for (int b = 0; b < c_nbytes; b++)
      if (reg_bus.reg_bytecnt == 16'(b)) w_fifo_byte = w_head_pad[b*8 +: 8];
    if (w_empty) w_fifo_byte = '0;
  end

  always_comb begin
    w_reg_byte = '0;
    if (reg_bus.reg_address == pREG_FIFO_STAT)
      w_reg_byte = sel_byte(48'(w_stat), reg_bus.reg_bytecnt, 1);
    else if (reg_bus.reg_address == pREG_FIFO_CNT)
      w_reg_byte = sel_byte({w_stats, 16'(w_count)}, reg_bus.reg_bytecnt, 6);
    else if (reg_bus.reg_address == pREG_FIFO_CTRL)
      w_reg_byte = sel_byte(48'({r_thr_full, r_thr_empty, r_state, 4'b0000, r_ctrl_arm}),
                            reg_bus.reg_bytecnt, 5);
    else if (reg_bus.reg_address == pREG_FIFO_LEN)
      w_reg_byte = sel_byte(48'(r_len), reg_bus.reg_bytecnt, 2);
  end

  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) r_read_data <= '0;
    else         r_read_data <= w_rd_reg ? w_reg_byte : 8'h00;
  end

  assign reg_bus.read_data = w_rd_fifo ? w_fifo_byte : r_read_data;
  assign O_full            = w_full;

endmodule

`default_nettype wire
